// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm shared types: state encodings, opcodes, ALU and trap codes.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IMMEX  = 4'd10,
    IMMWB  = 4'd11,
    TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wait_timer.sv
// mc_wait_timer: counts stalled cycles in a memory state and flags
// the cycle on which the wait limit is reached.
module mc_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic active,
  input  logic hold,
  input  logic MemReady,
  output logic timeout
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] cnt;
  logic         stall;

  assign stall   = (LIMIT != 0) && active && !MemReady;
  assign timeout = stall && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (Reset || !hold)
      cnt <= '0;
    else if (stall && cnt != LAST)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer with memory-wait trap.
// Define MC_CTRL_PERF_CNT_EN to add CycleCnt/InstrCnt counters.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PcWrite,
  output logic             PcSel,
  output logic             Jump,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       State,
`ifdef MC_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstrCnt,
`endif
  output logic             Trap,
  output logic [1:0]       TrapCause
);

  state_e     state_q, state_d;
  logic [1:0] cause_d;
  logic       timeout;
  logic       unused_funct;

  // Funct is decoded by the ALU control, not here
  assign unused_funct = ^Funct;

  assign State = state_q;
  assign Trap  = (state_q == TRAP);

  mc_wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait (
    .clk     (clk),
    .Reset   (Reset),
    .active  (is_mem_state(state_q)),
    .hold    (state_d == state_q),
    .MemReady(MemReady),
    .timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    cause_d = TC_NONE;
    case (state_q)
      FETCH: begin
        if (MemReady)
          state_d = DECODE;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      DECODE: begin
        unique case (1'b1)
          Op == OP_RTYPE:              state_d = EXEC;
          Op == OP_LW || Op == OP_SW:  state_d = MEMADR;
          Op == OP_BEQ:                state_d = BRANCH;
          Op == OP_J:                  state_d = JUMP;
          Op == OP_ADDI || Op == OP_ORI: state_d = IMMEX;
          default: begin
            state_d = TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end
      MEMADR: state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD, MEMWR: begin
        if (MemReady)
          state_d = (state_q == MEMRD) ? MEMWB : FETCH;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      EXEC:  state_d = ALUWB;
      IMMEX: state_d = IMMWB;
      MEMWB, ALUWB, BRANCH, JUMP, IMMWB: state_d = FETCH;
      TRAP:  state_d = TRAP;
      default: begin
        state_d = TRAP;
        cause_d = TC_ILLEGAL;
      end
    endcase
  end

  always_comb begin
    PcWrite  = 1'b0;
    PcSel    = 1'b0;
    Jump     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RT;
    ALUOp    = ALU_ADD;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PcWrite = MemReady;
      end
      DECODE: ALUSrcB = SRCB_SEXT;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PcSel   = 1'b1;
        PcWrite = Zero;
      end
      JUMP: begin
        Jump    = 1'b1;
        PcWrite = 1'b1;
      end
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (Op == OP_ORI) ? SRCB_ZEXT : SRCB_SEXT;
        ALUOp   = (Op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      IMMWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= FETCH;
      TrapCause <= TC_NONE;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP && state_q != TRAP)
        TrapCause <= cause_d;
    end
  end

`ifdef MC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      if (state_q != TRAP)
        CycleCnt <= CycleCnt + CNT_W'(1);
      if (state_d == FETCH && state_q != FETCH)
        InstrCnt <= InstrCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm with WAIT_LIMIT=4.
// Perf counter checks are built only with MC_CTRL_PERF_CNT_EN.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       Reset;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       PcWrite, PcSel, Jump, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, TrapCause;
  logic [3:0] State;
  logic       Trap;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] CycleCnt, InstrCnt;
`endif
  logic [14:0] ctl;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.WAIT_LIMIT(4), .CNT_W(32)) dut (
    .clk(clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PcWrite(PcWrite), .PcSel(PcSel), .Jump(Jump),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .State(State),
`ifdef MC_CTRL_PERF_CNT_EN
    .CycleCnt(CycleCnt), .InstrCnt(InstrCnt),
`endif
    .Trap(Trap), .TrapCause(TrapCause)
  );

  assign ctl = {PcWrite, PcSel, Jump, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp};

  // PcW PcS J IorD MRd MWr IRW RDst M2R RW SrcA SrcB ALUOp
  localparam logic [14:0] C_FETCH  = 15'b1_0_0_0_1_0_1_0_0_0_0_01_00;
  localparam logic [14:0] C_FSTALL = 15'b0_0_0_0_1_0_0_0_0_0_0_01_00;
  localparam logic [14:0] C_DEC    = 15'b0_0_0_0_0_0_0_0_0_0_0_10_00;
  localparam logic [14:0] C_MADR   = 15'b0_0_0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [14:0] C_MRD    = 15'b0_0_0_1_1_0_0_0_0_0_0_00_00;
  localparam logic [14:0] C_MWB    = 15'b0_0_0_0_0_0_0_0_1_1_0_00_00;
  localparam logic [14:0] C_MWR    = 15'b0_0_0_1_0_1_0_0_0_0_0_00_00;
  localparam logic [14:0] C_EXEC   = 15'b0_0_0_0_0_0_0_0_0_0_1_00_10;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_0_0_1_0_1_0_00_00;
  localparam logic [14:0] C_BRT    = 15'b1_1_0_0_0_0_0_0_0_0_1_00_01;
  localparam logic [14:0] C_BRNT   = 15'b0_1_0_0_0_0_0_0_0_0_1_00_01;
  localparam logic [14:0] C_JUMP   = 15'b1_0_1_0_0_0_0_0_0_0_0_00_00;
  localparam logic [14:0] C_ORI    = 15'b0_0_0_0_0_0_0_0_0_0_1_11_11;
  localparam logic [14:0] C_ADDI   = 15'b0_0_0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [14:0] C_IMMWB  = 15'b0_0_0_0_0_0_0_0_0_1_0_00_00;
  localparam logic [14:0] C_NONE   = 15'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // inputs already set at negedge; check settled outputs, then advance
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [14:0] c);
    #1;
    chk({tag, ".state"}, 32'(State), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    chk({tag, ".trap"}, 32'(Trap), 32'(st == 4'd12));
    @(negedge clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.state", 32'(State), 32'd0);
    chk("rst.trap", 32'(Trap), 32'd0);
    chk("rst.cause", 32'(TrapCause), 32'd0);
    Reset = 1'b0; MemReady = 1'b1; Op = 6'b000000; Funct = 6'h20;

    cyc("rt.fetch", 4'd0, C_FETCH);
    cyc("rt.dec", 4'd1, C_DEC);
    cyc("rt.exec", 4'd6, C_EXEC);
    cyc("rt.wb", 4'd7, C_ALUWB);

    Op = 6'b100011;
    cyc("lw.fetch", 4'd0, C_FETCH);
    cyc("lw.dec", 4'd1, C_DEC);
    MemReady = 1'b0;
    cyc("lw.madr", 4'd2, C_MADR);
    cyc("lw.rd0", 4'd3, C_MRD);
    cyc("lw.rd1", 4'd3, C_MRD);
    cyc("lw.rd2", 4'd3, C_MRD);
    MemReady = 1'b1;
    cyc("lw.rd3", 4'd3, C_MRD);
    cyc("lw.wb", 4'd4, C_MWB);

    Op = 6'b101011;
    cyc("sw.fetch", 4'd0, C_FETCH);
    cyc("sw.dec", 4'd1, C_DEC);
    cyc("sw.madr", 4'd2, C_MADR);
    cyc("sw.wr", 4'd5, C_MWR);

    Op = 6'b000100; Zero = 1'b1;
    cyc("beqt.fetch", 4'd0, C_FETCH);
    cyc("beqt.dec", 4'd1, C_DEC);
    cyc("beqt.br", 4'd8, C_BRT);
    Zero = 1'b0;
    cyc("beqn.fetch", 4'd0, C_FETCH);
    cyc("beqn.dec", 4'd1, C_DEC);
    cyc("beqn.br", 4'd8, C_BRNT);

    Op = 6'b000010;
    cyc("j.fetch", 4'd0, C_FETCH);
    cyc("j.dec", 4'd1, C_DEC);
    cyc("j.jump", 4'd9, C_JUMP);

    Op = 6'b001101;
    cyc("ori.fetch", 4'd0, C_FETCH);
    cyc("ori.dec", 4'd1, C_DEC);
    cyc("ori.ex", 4'd10, C_ORI);
    cyc("ori.wb", 4'd11, C_IMMWB);

    Op = 6'b001000;
    cyc("addi.fetch", 4'd0, C_FETCH);
    cyc("addi.dec", 4'd1, C_DEC);
    cyc("addi.ex", 4'd10, C_ADDI);
    cyc("addi.wb", 4'd11, C_IMMWB);

    // reset in the middle of an instruction
    Op = 6'b100011;
    cyc("mr.fetch", 4'd0, C_FETCH);
    cyc("mr.dec", 4'd1, C_DEC);
    Reset = 1'b1;
    cyc("mr.madr", 4'd2, C_MADR);
    Reset = 1'b0; MemReady = 1'b0;
    cyc("mr.after", 4'd0, C_FSTALL);
    MemReady = 1'b1;

    Op = 6'b111111;
    cyc("ill.fetch", 4'd0, C_FETCH);
    cyc("ill.dec", 4'd1, C_DEC);
    #1;
    chk("ill.cause", 32'(TrapCause), 32'd1);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("ill.trap%0d", i), 4'd12, C_NONE);
    do_reset();
    #1;
    chk("ill.rst.state", 32'(State), 32'd0);
    chk("ill.rst.trap", 32'(Trap), 32'd0);
    chk("ill.rst.cause", 32'(TrapCause), 32'd0);
    @(negedge clk);

    // timeout: that FETCH cycle was the first stalled one? no, ready=1
    do_reset();
    MemReady = 1'b0; Op = 6'b000000;
    for (int i = 0; i < 4; i++)
      cyc($sformatf("to.fetch%0d", i), 4'd0, C_FSTALL);
    #1;
    chk("to.cause", 32'(TrapCause), 32'd2);
    cyc("to.trap", 4'd12, C_NONE);

    do_reset();
    for (int i = 0; i < 3; i++)
      cyc($sformatf("lim.fetch%0d", i), 4'd0, C_FSTALL);
    MemReady = 1'b1;
    cyc("lim.fetch3", 4'd0, C_FETCH);
    cyc("lim.dec", 4'd1, C_DEC);
    chk("lim.cause", 32'(TrapCause), 32'd0);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("pc%0d.fetch", i), 4'd0, C_FETCH);
      cyc($sformatf("pc%0d.dec", i), 4'd1, C_DEC);
      cyc($sformatf("pc%0d.exec", i), 4'd6, C_EXEC);
      cyc($sformatf("pc%0d.wb", i), 4'd7, C_ALUWB);
    end
    #1;
    chk("pc.state", 32'(State), 32'd0);
`ifdef MC_CTRL_PERF_CNT_EN
    chk("pc.instr", InstrCnt, 32'd3);
    chk("pc.cycle", CycleCnt, 32'd12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
